// File: rtl/vga_timing_pkg.sv
// Shared XGA (1024x768@60, 65 MHz) timing constants and counter type
// for the video timing generator.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/timing_axis.sv
// One video timing axis: wrapping position counter with registered blank and
// sync decode taken from the next count, so flags line up with the count.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE           = XGA_H_ACTIVE,
  parameter int FP               = XGA_H_FP,
  parameter int SYNC             = XGA_H_SYNC,
  parameter int BP               = XGA_H_BP,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output cnt_t count,
  output logic blnk,
  output logic sync,
  output logic wrap
);

  localparam int   TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
  localparam cnt_t BLNK_START = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_START = cnt_t'(ACTIVE + FP);
  localparam cnt_t SYNC_END   = cnt_t'(ACTIVE + FP + SYNC - 1);
  localparam logic SYNC_ON    = SYNC_ACTIVE_HIGH;
  localparam logic SYNC_OFF   = !SYNC_ACTIVE_HIGH;

  if (TOTAL > 2047) begin : g_total_check
    $error("timing_axis: total %0d does not fit an 11-bit counter", TOTAL);
  end

  cnt_t count_next;

  assign wrap = inc && (count == LAST);

  // NOTE: default assignment first so every path drives count_next (no latch).
  always_comb begin
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (inc)
      count_next = count + cnt_t'(1);
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= SYNC_OFF;
    end else begin
      count <= count_next;
      blnk  <= (count_next >= BLNK_START);
      sync  <= (count_next >= SYNC_START && count_next <= SYNC_END) ? SYNC_ON : SYNC_OFF;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing source for the drawing pipeline: horizontal/vertical counts,
// sync, blanking and line/frame start strobes, all registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE         = XGA_H_ACTIVE,
  parameter int H_FP             = XGA_H_FP,
  parameter int H_SYNC           = XGA_H_SYNC,
  parameter int H_BP             = XGA_H_BP,
  parameter int V_ACTIVE         = XGA_V_ACTIVE,
  parameter int V_FP             = XGA_V_FP,
  parameter int V_SYNC           = XGA_V_SYNC,
  parameter int V_BP             = XGA_V_BP,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic             line_start,
  output logic             frame_start
);

  logic h_wrap;
  logic v_wrap;
  logic v_inc;

  // The vertical axis steps once per completed line.
  assign v_inc = en && h_wrap;

  timing_axis #(
    .ACTIVE           (H_ACTIVE),
    .FP               (H_FP),
    .SYNC             (H_SYNC),
    .BP               (H_BP),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_h_axis (
    .clk   (pclk),
    .rst_n (rst_n),
    .inc   (en),
    .count (hcount_out),
    .blnk  (hblnk_out),
    .sync  (hsync_out),
    .wrap  (h_wrap)
  );

  timing_axis #(
    .ACTIVE           (V_ACTIVE),
    .FP               (V_FP),
    .SYNC             (V_SYNC),
    .BP               (V_BP),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_v_axis (
    .clk   (pclk),
    .rst_n (rst_n),
    .inc   (v_inc),
    .count (vcount_out),
    .blnk  (vblnk_out),
    .sync  (vsync_out),
    .wrap  (v_wrap)
  );

  // Wrap flags already include en, so a frozen cycle yields zero strobes.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-timing bus consumed by the drawing pipeline stages.
- Generates hcount/vcount, hsync/vsync and hblnk/vblnk for 1024x768@60 (65 MHz pixel clock), plus line/frame start strobes.
- Sits at the head of the video chain; its outputs feed the first draw stage directly, with no glue logic.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
SYNC_ACTIVE_HIGH, 0, sync polarity; 0 = sync pulse driven low (XGA standard)

Ports:
pclk  in  1  pixel clock, 65 MHz
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
en  in  1  count enable; low freezes timing
hcount_out  out  11  horizontal position, 0..H_TOTAL-1
vcount_out  out  11  vertical position, 0..V_TOTAL-1
hsync_out  out  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH
vsync_out  out  1  vertical sync, polarity per SYNC_ACTIVE_HIGH
hblnk_out  out  1  high while hcount_out >= H_ACTIVE
vblnk_out  out  1  high while vcount_out >= V_ACTIVE
line_start  out  1  one-cycle pulse when hcount_out becomes 0 by wrap
frame_start  out  1  one-cycle pulse when (hcount_out, vcount_out) becomes (0,0) by wrap

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = 806. All counters are 11 bits; parameters must keep totals <= 2047.
- Reset (rst_n low, asynchronous): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync/vsync at their inactive level, line_start=0, frame_start=0.
- All outputs are registers. Decode is computed from the next counter values, so every output in a given cycle describes the hcount_out/vcount_out shown in that same cycle (zero skew between count and flags).
- Rising edge with en=1:
  - If hcount == H_TOTAL-1: hcount goes to 0 and line_start=1.
    - If vcount == V_TOTAL-1 at that point: vcount goes to 0 and frame_start=1.
    - Otherwise vcount increments.
  - Otherwise hcount increments.
- Rising edge with en=0: counters and all level outputs hold; line_start and frame_start are driven 0.
- hblnk asserted for hcount in [H_ACTIVE, H_TOTAL-1], i.e. [1024, 1343].
- hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [1048, 1183].
- vblnk asserted for vcount in [768, 805].
- vsync active for vcount in [771, 776], for the entire line including the horizontal blanking part.
- The first cycle after reset release shows (0,0) with both strobes 0. Strobes fire only on wrap, never on reset exit.
- Reset asserted mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge; counting restarts from (0,0).
- Frame period: 1344*806 = 1,083,264 enabled cycles.

Decomposition:
- Package vga_timing_pkg holds: the default XGA timing constants, the derived H_TOTAL/V_TOTAL, and the 11-bit counter width.
- One sub-module is natural: timing_axis. It is a wrapping counter plus blank/sync window decode, with increment-enable and wrap outputs. It is instantiated twice, horizontal and vertical; the vertical instance's enable is en AND the horizontal wrap.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles -> counts 0/0, blanks 0, syncs inactive (1 with default polarity), strobes 0. Release -> next edge shows hcount=1.
- Horizontal line: run one line -> hblnk rises when hcount=1024; hsync goes low at 1048 and high at 1184; at 1343->0, vcount increments and line_start pulses for exactly 1 cycle.
- Vertical frame: run a full frame -> vblnk rises at vcount=768; vsync is low for lines 771..776 inclusive; (1343,805)->(0,0) pulses frame_start; frame period measures 1,083,264 cycles.
- Enable: drop en for 50 cycles at hcount=1343 -> hcount, vcount and flags frozen, strobes 0 throughout; on re-enable the next edge wraps to 0 with line_start=1.
- Async reset mid-frame: assert rst_n at (500,400) between clock edges -> outputs reach reset values before the next pclk edge; after release, counting resumes from 0 with no spurious frame_start.
- Polarity: SYNC_ACTIVE_HIGH=1 -> hsync high only within [1048, 1183] and vsync high only within lines [771, 776]; reset level is 0.
